multicycle_cpu: RTL and testbench

MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

---
 rtl/multicycle_cpu_pkg.sv | 71 +++++++
 rtl/cpu_regfile_ar.sv | 29 ++
 rtl/multicycle_cpu.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_cpu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_cpu_pkg.sv
// rtl/multicycle_cpu_pkg.sv - opcodes, state encoding and ALU operations for multicycle_cpu
package multicycle_cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_SLT = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    function automatic logic op_supported(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        case (op)
            OP_RTYPE: ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_SLT) || (fn == FN_JR);
            OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_XORI, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Address generation for LW/SW reuses ALU_ADD.
    function automatic alu_op_e alu_op_of(input logic [5:0] op, input logic [5:0] fn);
        alu_op_e sel;
        sel = ALU_ADD;
        if (op == OP_XORI) begin
            sel = ALU_XOR;
        end else if (op == OP_RTYPE && fn == FN_SUB) begin
            sel = ALU_SUB;
        end else if (op == OP_RTYPE && fn == FN_SLT) begin
            sel = ALU_SLT;
        end
        return sel;
    endfunction

    function automatic logic [31:0] alu_eval(input alu_op_e op, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        case (op)
            ALU_ADD: r = x + y;
            ALU_SUB: r = x - y;
            ALU_SLT: r = {31'b0, ($signed(x) < $signed(y))};
            default: r = x ^ y;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_regfile_ar.sv
// rtl/cpu_regfile_ar.sv - 32x32 register file, two async read ports, one sync write port
module cpu_regfile_ar (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  raddr_a_i,
    output logic [31:0] rdata_a_o,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_b_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'h0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'h0 : regs_q[raddr_b_i];

endmodule

// File: rtl/multicycle_cpu.sv
// rtl/multicycle_cpu.sv - multicycle MIPS-I subset core with a single req/ready memory port
module multicycle_cpu #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       JAL_REG  = 31
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_out
);

    import multicycle_cpu_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       imm_q, imm_d;
    logic [31:0]       res_q, res_d;

    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd;
    logic              is_rtype;
    logic [31:0]       rs_data, rt_data;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;

    logic [ADDR_W-1:0] pc_plus4, br_target, j_target;
    logic [31:0]       pc4_ext, j_target_ext, imm_shift, alu_b, alu_y;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign is_rtype = (opcode == OP_RTYPE);

    assign pc_plus4     = pc_q + ADDR_W'(4);
    assign imm_shift    = {imm_q[29:0], 2'b00};
    assign br_target    = pc_plus4 + imm_shift[ADDR_W-1:0];
    assign pc4_ext      = 32'(pc_plus4);
    assign j_target_ext = {pc4_ext[31:28], ir_q[25:0], 2'b00};
    assign j_target     = j_target_ext[ADDR_W-1:0];

    // XORI is the only immediate that zero-extends; imm_q holds the sign-extended form.
    always_comb begin
        alu_b = imm_q;
        if (is_rtype) begin
            alu_b = b_q;
        end else if (opcode == OP_XORI) begin
            alu_b = {16'h0, imm_q[15:0]};
        end
    end

    assign alu_y = alu_eval(alu_op_of(opcode, funct), a_q, alu_b);

    cpu_regfile_ar u_regfile (
        .clk_i     (clk),
        .rst_i     (reset),
        .raddr_a_i (rs),
        .rdata_a_o (rs_data),
        .raddr_b_i (rt),
        .rdata_b_o (rt_data),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        res_d    = res_q;
        rf_we    = 1'b0;
        rf_waddr = is_rtype ? rd : rt;
        rf_wdata = res_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                a_d     = rs_data;
                b_d     = rt_data;
                imm_d   = {{16{ir_q[15]}}, ir_q[15:0]};
                state_d = op_supported(opcode, funct) ? ST_EXECUTE : ST_HALT;
            end
            ST_EXECUTE: begin
                res_d   = alu_y;
                state_d = ST_FETCH;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            pc_d = a_q[ADDR_W-1:0];
                        end else begin
                            state_d = ST_WRITEBACK;
                        end
                    end
                    OP_ADDI, OP_XORI: state_d = ST_WRITEBACK;
                    OP_LW, OP_SW:     state_d = ST_MEMORY;
                    OP_BEQ:           pc_d = (a_q == b_q) ? br_target : pc_plus4;
                    OP_BNE:           pc_d = (a_q != b_q) ? br_target : pc_plus4;
                    OP_J:             pc_d = j_target;
                    OP_JAL: begin
                        pc_d     = j_target;
                        rf_we    = 1'b1;
                        rf_waddr = 5'(JAL_REG);
                        rf_wdata = pc4_ext;
                    end
                    default:          state_d = ST_HALT;
                endcase
            end
            ST_MEMORY: begin
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        pc_d    = pc_plus4;
                        state_d = ST_FETCH;
                    end else begin
                        res_d   = mem_rdata;
                        state_d = ST_WRITEBACK;
                    end
                end
            end
            ST_WRITEBACK: begin
                rf_we   = 1'b1;
                pc_d    = pc_plus4;
                state_d = ST_FETCH;
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            res_q   <= res_d;
        end
    end

    // Gated by reset so an asserted reset kills an in-flight access in the same instant.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (state_q == ST_FETCH) begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
            end else if (state_q == ST_MEMORY) begin
                mem_req  = 1'b1;
                mem_addr = res_q[ADDR_W-1:0];
                if (opcode == OP_SW) begin
                    mem_we    = 1'b1;
                    mem_wdata = b_q;
                end
            end
        end
    end

    assign halted = (state_q == ST_HALT);
    assign pc_out = pc_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// tb/tb_multicycle_cpu.sv - directed self-checking bench for multicycle_cpu
`timescale 1ns/1ps
module tb_multicycle_cpu;
    import multicycle_cpu_pkg::*;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

    multicycle_cpu dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted),
        .pc_out    (pc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } acc_t;

    acc_t        acc_q[$];
    logic [31:0] rom    [256];
    logic [31:0] dmem   [256];
    logic        dvalid [256];
    int          wait_cycles = 0;
    int          wcnt = 0, cyc = 0, store_total = 0, waits = 0, unstable = 0;
    logic        prev_wait = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    int          n_checks = 0, n_errors = 0;
    logic [7:0]  widx;

    assign widx      = mem_addr[9:2];
    assign mem_rdata = dvalid[widx] ? dmem[widx] : rom[widx];
    assign mem_ready = mem_req && (wcnt >= wait_cycles);

    // Memory model: stores overlay the program image until the next reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt <= 0;
            cyc  <= 0;
            acc_q.delete();
            for (int i = 0; i < 256; i++) dvalid[i] <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (mem_req && !mem_ready) wcnt <= wcnt + 1;
            else wcnt <= 0;
            if (mem_req && mem_ready) begin
                acc_q.push_back('{we: mem_we, addr: mem_addr, data: (mem_we ? mem_wdata : 32'h0), cyc: cyc + 1});
                if (mem_we) begin
                    dmem[widx]   <= mem_wdata;
                    dvalid[widx] <= 1'b1;
                    store_total  <= store_total + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (prev_wait && !reset &&
            (!mem_req || mem_we !== p_we || mem_addr !== p_addr || mem_wdata !== p_wdata))
            unstable <= unstable + 1;
        if (mem_req && !mem_ready) waits <= waits + 1;
        prev_wait <= mem_req && !mem_ready;
        p_we      <= mem_we;
        p_addr    <= mem_addr;
        p_wdata   <= mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_acc(input string tag, input int idx, input logic we,
                             input logic [31:0] addr, input logic [31:0] data, input int exp_cyc);
        check_eq({tag, "_seen"}, 64'(acc_q.size() > idx), 64'd1);
        if (acc_q.size() > idx) begin
            check_eq(tag, {acc_q[idx].we, acc_q[idx].addr[30:0], acc_q[idx].data},
                          {we, addr[30:0], data});
            if (exp_cyc > 0) check_eq({tag, "_cycle"}, 64'(acc_q[idx].cyc), 64'(exp_cyc));
        end
    endtask

    task automatic wait_halt(input string tag, input int limit);
        for (int i = 0; i < limit && !halted; i++) @(negedge clk);
        check_eq({tag, "_halted"}, 64'(halted), 64'd1);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 32'hFC00_0000;
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

    initial begin
        int w0, st0, req_seen;

        #1 reset = 1'b1;
        #1;
        check_eq("rst_mem_req",   64'(mem_req),   64'd0);
        check_eq("rst_mem_we",    64'(mem_we),    64'd0);
        check_eq("rst_mem_addr",  64'(mem_addr),  64'd0);
        check_eq("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check_eq("rst_halted",    64'(halted),    64'd0);
        check_eq("rst_pc",        64'(pc_out),    64'd0);
        check_eq("rst_r31",       64'(dut.u_regfile.regs_q[31]), 64'd0);

        // Program A: ALU ops, BNE, SLT, JAL/JR, XORI, SW, illegal opcode, zero-wait memory
        clear_rom();
        rom[0]  = enc_i(OP_ADDI, 0, 1, 16'd5);
        rom[1]  = enc_i(OP_ADDI, 0, 2, 16'd7);
        rom[2]  = enc_r(1, 2, 3, FN_ADD);
        rom[3]  = enc_r(1, 2, 4, FN_SUB);
        rom[4]  = enc_i(OP_BNE, 1, 2, 16'd2);
        rom[5]  = enc_i(OP_ADDI, 0, 9, 16'd1);
        rom[6]  = enc_i(OP_ADDI, 0, 9, 16'd2);
        rom[7]  = enc_r(4, 1, 5, FN_SLT);
        rom[8]  = enc_j(OP_JAL, 26'h40);
        rom[9]  = enc_i(OP_XORI, 1, 6, 16'h8003);
        rom[10] = enc_i(OP_SW, 0, 3, 16'd8);
        rom[64] = enc_r(31, 0, 0, FN_JR);
        wait_cycles = 0;
        @(negedge clk) reset = 1'b0;
        repeat (11) @(posedge clk);
        #1 check_eq("A_r3_cycle11", 64'(dut.u_regfile.regs_q[3]), 64'd0);
        @(posedge clk);
        #1 check_eq("A_r3_cycle12", 64'(dut.u_regfile.regs_q[3]), 64'd12);
        wait_halt("A", 200);
        check_acc("A_f00", 0,  1'b0, 32'h00,  32'h0, 1);
        check_acc("A_f04", 1,  1'b0, 32'h04,  32'h0, 5);
        check_acc("A_f08", 2,  1'b0, 32'h08,  32'h0, 9);
        check_acc("A_f0c", 3,  1'b0, 32'h0C,  32'h0, 13);
        check_acc("A_f10", 4,  1'b0, 32'h10,  32'h0, 17);
        check_acc("A_bne", 5,  1'b0, 32'h1C,  32'h0, 20);
        check_acc("A_f20", 6,  1'b0, 32'h20,  32'h0, 24);
        check_acc("A_jal", 7,  1'b0, 32'h100, 32'h0, 27);
        check_acc("A_jr",  8,  1'b0, 32'h24,  32'h0, 30);
        check_acc("A_f28", 9,  1'b0, 32'h28,  32'h0, 34);
        check_acc("A_sw",  10, 1'b1, 32'h08,  32'd12, 37);
        check_acc("A_f2c", 11, 1'b0, 32'h2C,  32'h0, 38);
        check_eq("A_nacc", 64'(acc_q.size()), 64'd12);
        check_eq("A_r4_sub",  64'(dut.u_regfile.regs_q[4]),  64'hFFFF_FFFE);
        check_eq("A_r5_slt",  64'(dut.u_regfile.regs_q[5]),  64'd1);
        check_eq("A_r6_xori", 64'(dut.u_regfile.regs_q[6]),  64'h8006);
        check_eq("A_r9_skip", 64'(dut.u_regfile.regs_q[9]),  64'd0);
        check_eq("A_r31_jal", 64'(dut.u_regfile.regs_q[31]), 64'h24);
        check_eq("A_halt_pc", 64'(pc_out),  64'h2C);
        check_eq("A_halt_req", 64'(mem_req), 64'd0);

        // Program B: BEQ not taken, SW/LW round trip, r0 write discard, 3-cycle memory waits
        reset = 1'b1;
        clear_rom();
        rom[0]  = enc_i(OP_ADDI, 0, 1, 16'd5);
        rom[1]  = enc_i(OP_ADDI, 0, 2, 16'd7);
        rom[2]  = enc_r(1, 2, 3, FN_ADD);
        rom[3]  = enc_i(OP_ADDI, 0, 0, 16'd9);
        rom[4]  = enc_i(OP_BEQ, 1, 2, 16'd2);
        rom[5]  = enc_i(OP_SW, 0, 3, 16'd8);
        rom[6]  = enc_i(OP_LW, 0, 4, 16'd8);
        rom[7]  = enc_i(OP_SW, 0, 4, 16'h40);
        rom[8]  = enc_r(0, 1, 5, FN_ADD);
        rom[9]  = enc_i(OP_SW, 0, 5, 16'h44);
        wait_cycles = 3;
        w0 = waits;
        @(negedge clk) reset = 1'b0;
        wait_halt("B", 600);
        check_acc("B_beq", 5,  1'b0, 32'h14, 32'h0,  0);
        check_acc("B_sw8", 6,  1'b1, 32'h08, 32'd12, 0);
        check_acc("B_lw8", 8,  1'b0, 32'h08, 32'h0,  0);
        check_acc("B_r4",  10, 1'b1, 32'h40, 32'd12, 0);
        check_acc("B_r0",  13, 1'b1, 32'h44, 32'd5,  0);
        check_eq("B_nacc",   64'(acc_q.size()), 64'd15);
        check_eq("B_waits",  64'(waits - w0), 64'd45);
        check_eq("B_stable", 64'(unstable), 64'd0);

        // Reset asserted while a store is waiting for mem_ready
        reset = 1'b1;
        clear_rom();
        rom[0] = enc_i(OP_ADDI, 0, 1, 16'd5);
        rom[1] = enc_i(OP_SW, 0, 1, 16'h20);
        wait_cycles = 3;
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 100 && !(mem_req && mem_we); i++) @(negedge clk);
        check_eq("C_sw_waiting", 64'({mem_req, mem_we, mem_ready}), 64'b110);
        st0 = store_total;
        #2 reset = 1'b1;
        #1;
        check_eq("C_req_drop", 64'(mem_req), 64'd0);
        check_eq("C_we_drop",  64'(mem_we),  64'd0);
        check_eq("C_state",    64'(dut.state_q), 64'(ST_FETCH));
        check_eq("C_pc",       64'(pc_out), 64'd0);
        check_eq("C_r1_clear", 64'(dut.u_regfile.regs_q[1]), 64'd0);
        repeat (3) @(posedge clk);
        #1 check_eq("C_no_store", 64'(store_total), 64'(st0));

        // Illegal opcode halts after DECODE and stays quiet until reset
        clear_rom();
        wait_cycles = 0;
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1 check_eq("D_decode_not_halted", 64'(halted), 64'd0);
        @(posedge clk);
        #1 check_eq("D_halted", 64'(halted), 64'd1);
        req_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (mem_req) req_seen++;
        end
        check_eq("D_no_req",     64'(req_seen), 64'd0);
        check_eq("D_still_halt", 64'(halted),   64'd1);
        reset = 1'b1;
        rom[0] = enc_i(OP_ADDI, 0, 1, 16'd3);
        rom[1] = enc_i(OP_SW, 0, 1, 16'h10);
        @(negedge clk) reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_acc("D_resume", 0, 1'b0, 32'h00, 32'h0, 1);
        check_acc("D_f04",    1, 1'b0, 32'h04, 32'h0, 5);
        check_acc("D_sw",     2, 1'b1, 32'h10, 32'd3, 8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
